// File: rtl/traffic_control_unit.sv
// Control unit for the four-way traffic light controller: sequences right-of-way among
// North/South/East/West from latched sensor requests, a round-robin pick and tick timers.
module traffic_control_unit #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 4
) (
  input  logic       CU_CLK,
  input  logic       CU_Rst,
  input  logic       CU_Tick,
  input  logic [3:0] CU_Req,
  input  logic       CU_Hold,
  output logic       CU_North,
  output logic       CU_South,
  output logic       CU_East,
  output logic       CU_West,
  output logic [1:0] CU_Phase,
  output logic [3:0] CU_Pending
);

  // State encoding doubles as the phase code driven to the datapath.
  typedef enum logic [1:0] {
    ALL_RED = 2'b00,
    GREEN   = 2'b01,
    YELLOW  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_MIN_C = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] GREEN_MAX_C = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] YELLOW_C    = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ALLRED_C    = CNT_W'(ALLRED_T);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] timer;
  logic [1:0]       cur_dir;
  logic [1:0]       next_dir;
  logic [1:0]       sel_dir;
  logic             sel_valid;
  logic [3:0]       req_meta;
  logic [3:0]       req_s;
  logic [3:0]       pending;
  logic [3:0]       next_pending;
  logic [3:0]       cur_mask;
  logic [3:0]       green_mask;
  logic [3:0]       enter_mask;
  logic             competing;
  logic             go_yellow;
  logic [3:0]       grant;

  // Two-flop synchronizer for the asynchronous vehicle sensors.
  always_ff @(posedge CU_CLK or negedge CU_Rst) begin
    if (!CU_Rst) begin
      req_meta <= '0;
      req_s    <= '0;
    end else begin
      // NOTE: non-blocking so each flop samples its pre-edge input; blocking would merge the two stages.
      req_meta <= CU_Req;
      req_s    <= req_meta;
    end
  end

  assign cur_mask  = 4'b0001 << cur_dir;
  assign competing = |(pending & ~cur_mask);
  assign go_yellow = CU_Hold ||
                     (competing && (timer >= GREEN_MAX_C ||
                                    (timer >= GREEN_MIN_C && !req_s[cur_dir])));

  // Round-robin pick: first pending direction after cur_dir, with cur_dir itself last.
  always_comb begin
    sel_valid = 1'b0;
    sel_dir   = cur_dir;
    for (int k = 1; k <= 4; k++) begin
      if (!sel_valid && pending[cur_dir + 2'(k)]) begin
        sel_valid = 1'b1;
        sel_dir   = cur_dir + 2'(k);
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; a missing default infers a latch.
    next_state = state;
    next_dir   = cur_dir;
    unique case (state)
      ALL_RED: begin
        if (!CU_Hold && timer >= ALLRED_C && sel_valid) begin
          next_state = GREEN;
          next_dir   = sel_dir;
        end
      end
      GREEN: begin
        if (go_yellow) next_state = YELLOW;
      end
      YELLOW: begin
        if (timer >= YELLOW_C) next_state = ALL_RED;
      end
      default: next_state = ALL_RED;
    endcase
  end

  // A green direction ignores its own sensor; the grant edge clears it and beats a same-edge set.
  assign green_mask   = (state == GREEN) ? cur_mask : 4'b0000;
  assign enter_mask   = (next_state == GREEN && state != GREEN) ? (4'b0001 << next_dir) : 4'b0000;
  assign next_pending = (pending | (req_s & ~green_mask)) & ~enter_mask;

  always_ff @(posedge CU_CLK or negedge CU_Rst) begin
    if (!CU_Rst) begin
      state    <= ALL_RED;
      cur_dir  <= 2'd3;
      timer    <= '0;
      pending  <= '0;
      grant    <= '0;
      CU_Phase <= 2'b00;
    end else begin
      state   <= next_state;
      cur_dir <= next_dir;
      pending <= next_pending;
      // Held at zero during an all-red hold so clearance restarts once the hold drops.
      if (next_state != state || (state == ALL_RED && CU_Hold)) begin
        timer <= '0;
      end else if (CU_Tick && timer < GREEN_MAX_C) begin
        timer <= timer + 1'b1;
      end
      // Outputs registered from the next state, so they change on the same edge as the state.
      grant    <= (next_state == ALL_RED) ? 4'b0000 : (4'b0001 << next_dir);
      CU_Phase <= next_state;
    end
  end

  assign CU_North   = grant[0];
  assign CU_South   = grant[1];
  assign CU_East    = grant[2];
  assign CU_West    = grant[3];
  assign CU_Pending = pending;

endmodule

// File: doc/traffic_control_unit.md
Name: traffic_control_unit

Overview:
- Control unit (CU) for the four-way traffic light controller datapath.
- Sequences right-of-way among North/South/East/West using vehicle-sensor requests, a round-robin scheduler and tick-based phase timers.
- Drives the datapath's one-hot direction controls and a phase code. The datapath decodes these into per-direction 2-bit light outputs.
- CU_Tick comes from the clock divider; CU_Hold comes from the datapath flag.

Parameters:
- GREEN_MIN, 4: minimum green duration, in ticks.
- GREEN_MAX, 12: green duration after which a competing request forces a change, in ticks.
- YELLOW_T, 3: yellow duration, in ticks.
- ALLRED_T, 2: all-red clearance duration, in ticks.
- CNT_W, 4: phase timer width. Must hold GREEN_MAX.

Ports:
- CU_CLK  in  1  system clock.
- CU_Rst  in  1  asynchronous, active-low reset.
- CU_Tick  in  1  one-cycle timebase pulse; timers advance only when it is 1.
- CU_Req  in  4  vehicle sensors, asynchronous: [0]=North, [1]=South, [2]=East, [3]=West.
- CU_Hold  in  1  datapath fault/emergency flag; forces all-red.
- CU_North  out  1  North has right-of-way (green or yellow).
- CU_South  out  1  South has right-of-way.
- CU_East  out  1  East has right-of-way.
- CU_West  out  1  West has right-of-way.
- CU_Phase  out  2  phase code: 00 all-red, 01 green, 10 yellow; 11 never driven.
- CU_Pending  out  4  latched outstanding requests, for the datapath and debug.

Behaviour:
- Reset (CU_Rst=0, asynchronous):
  - state=ALL_RED, timer=0, cur_dir=West (3), pending=0, sync flops=0.
  - All grants 0, CU_Phase=00.
- Request path:
  - CU_Req passes through a 2-FF synchronizer, giving req_s.
  - pending[i] is set on any edge where req_s[i]=1.
  - pending[i] is cleared on the edge entering GREEN for direction i; clear wins over set on that edge.
  - pending[i] is not set while direction i is GREEN; setting resumes in YELLOW.
- Timer:
  - Cleared on every state change.
  - Increments on edges where CU_Tick=1 and the state is not changing.
  - Saturates at GREEN_MAX.
- ALL_RED:
  - Grants 0, CU_Phase=00.
  - When timer>=ALLRED_T and CU_Hold=0, select the first set pending bit scanning cur_dir+1, +2, +3, +0 (mod 4). Go to GREEN, cur_dir=selected, timer=0.
  - No pending bit: remain in ALL_RED (idle); timer stays saturated.
- GREEN:
  - One-hot grant for cur_dir, CU_Phase=01.
  - Go to YELLOW when any pending bit other than cur_dir is set AND (timer>=GREEN_MAX OR (timer>=GREEN_MIN AND req_s[cur_dir]=0)).
  - With no competing request, green rests indefinitely.
  - CU_Hold=1 goes to YELLOW immediately, with no GREEN_MIN wait.
- YELLOW:
  - Same grant as GREEN, CU_Phase=10.
  - Goes to ALL_RED when timer>=YELLOW_T; CU_Hold has no effect here.
- CU_Hold in ALL_RED: blocks selection. Leaving ALL_RED requires a further ALLRED_T ticks after CU_Hold drops, because the timer is held at 0 while CU_Hold=1.
- Outputs are registered, decoded from state and cur_dir. At most one grant is 1 in any cycle.
- Transition latency:
  - Grant changes one edge after the enabling condition.
  - Request-to-pending latency is 3 edges.
- Reset mid-operation: outputs go to reset values immediately, independent of CU_CLK; pending requests are lost.

Test Plan:
- Reset release, CU_Tick=1 every cycle, CU_Req=0 -> CU_Phase=00 and grants 0 for 100 cycles; CU_Pending=0.
- One-cycle CU_Req=0001 pulse after 10 cycles -> CU_Pending[0]=1 three edges later. Next edge: CU_North=1, CU_Phase=01, CU_Pending=0. Green persists 50 cycles with no other request.
- North green, req North low, CU_Req=0100 (East) at timer=1 -> YELLOW at timer=4. Then 3 cycles YELLOW, 2 cycles ALL_RED, then CU_East=1 with CU_Phase=01.
- North green with CU_Req[0] held high, South request raised at timer=2 -> North stays green until timer=12, then yellow/all-red, then CU_South=1. North re-pending is served after South.
- From ALL_RED with cur_dir=North and all four pending, competing requests held -> grant order South, East, West, North; never two grants at once.
- CU_Hold=1 at green timer=1 -> YELLOW next edge, then ALL_RED held while CU_Hold=1. After release, green after ALLRED_T=2 ticks.
- CU_Rst=0 mid-yellow -> grants 0 and CU_Phase=00 asynchronously.
